arb_rr_8: RTL
=============

ARB_RR_8 -- requirements
Module: arb_rr_8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per requester while others wait; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  8  request vector, bit i = requester i; level-held until served.
REQ-005 Port: gnt  output  8  registered one-hot grant, or all-zero.
REQ-006 Port: gnt_id  output  3  binary index of granted requester; 0 when gnt is zero.
REQ-007 Port: gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-008 Port: idle  output  1  high when state is IDLE and req is all-zero (combinational from state and req).

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and BUSY (one grant held).
REQ-010 Pick rule SHALL be rotating priority: search order ptr, ptr+1, ..., ptr+7 (mod 8); the first set candidate bit wins.
REQ-011 IDLE -> BUSY SHALL occur on the edge where req is non-zero; gnt is registered, so latency from req to gnt is 1 cycle.
REQ-012 In BUSY, gnt SHALL stay constant while req[gnt_id] remains high and the forced rotation of REQ-014 does not apply.
REQ-013 Release: when req[gnt_id] is sampled low, the same edge SHALL set ptr = gnt_id+1 (mod 8) and pick from req with bit gnt_id masked; a non-empty pick stays in BUSY with the new grant (no bubble); an empty pick goes to IDLE.
REQ-014 Forced rotation: hold_cnt counts BUSY cycles of the current grant; when hold_cnt == MAX_HOLD-1 and any other req bit is set, the edge SHALL rotate exactly as in REQ-013 even though req[gnt_id] is still high.
REQ-015 If hold_cnt reaches MAX_HOLD-1 with no other requester, the grant SHALL be kept and hold_cnt saturates at MAX_HOLD-1.
REQ-016 hold_cnt SHALL reset to 0 on every new grant, including back-to-back grants.
REQ-017 ptr SHALL change only on release or forced rotation; it does not change on the IDLE -> BUSY transition.
REQ-018 gnt SHALL never have more than one bit set, and SHALL never select a requester whose req bit was low at the sampling edge.
REQ-019 A req bit rising during BUSY SHALL have no effect until the next release or rotation.

Reset
REQ-020 While rst is high: state = IDLE, ptr = 0, hold_cnt = 0, gnt = 0, gnt_id = 0, gnt_valid = 0; idle then follows req.
REQ-021 Reset asserted mid-grant SHALL drop gnt immediately and asynchronously; the first edge after deassertion arbitrates with ptr = 0.

Structure
REQ-022 Shared package arb_pkg SHALL hold the state enum (IDLE, BUSY), constant ARB_N = 8 and ARB_IDW = 3.
REQ-023 Sub-module rr_pick SHALL hold the combinational rotating-priority pick: inputs are an 8-bit candidate vector and a 3-bit ptr; outputs are a one-hot vector, a 3-bit index and a found flag.
REQ-024 arb_rr_8 SHALL contain the FSM, ptr, hold_cnt, the masking logic and the output registers.

Verification
REQ-025 Reset then req=8'h00 -> gnt=0, idle=1. Then req=8'h81 -> 1 cycle later gnt=8'h01, gnt_id=0, gnt_valid=1, idle=0.
REQ-026 Back-to-back: hold req=8'h81 and drop bit0 after 3 grant cycles -> next cycle gnt=8'h80, with no zero cycle between the two grants; ptr=1.
REQ-027 Fairness: ptr=1 and req=8'h03 held continuously with MAX_HOLD=4 -> grant sequence 1,0,1,0, each held exactly 4 cycles.
REQ-028 Saturation: req=8'h04 only, held for 40 cycles with MAX_HOLD=16 -> gnt=8'h04 throughout and no rotation.
REQ-029 Wrap: grant on id 7 is released with req=8'h41 -> ptr=0, next gnt=8'h01.
REQ-030 Mid-grant reset: rst pulsed while gnt=8'h10 -> gnt=0 asynchronously; with req=8'h30 after release of rst -> gnt=8'h10 (ptr=0 order).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int ARB_N   = 8;
  localparam int ARB_IDW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef logic [ARB_N-1:0]   arb_vec_t;
  typedef logic [ARB_IDW-1:0] arb_id_t;

  // Successor index; the 3-bit width provides the mod-8 wrap.
  function automatic arb_id_t next_id(input arb_id_t id);
    return id + arb_id_t'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: scans cand starting at ptr and
// returns the first set bit as one-hot, binary index and a found flag.
module rr_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]   cand,
  input  logic [ARB_IDW-1:0] ptr,
  output logic [ARB_N-1:0]   onehot,
  output logic [ARB_IDW-1:0] idx,
  output logic               found
);

  always_comb begin : p_scan
    arb_id_t pos;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < ARB_N; i++) begin
      pos = ptr + arb_id_t'(i);
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

  assign onehot = found ? (arb_vec_t'(1) << idx) : '0;

endmodule

// File: rtl/arb_rr_8.sv
// 8-requester round-robin arbiter with registered one-hot grant, release
// without bubble, and forced rotation after MAX_HOLD cycles of contention.
module arb_rr_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ARB_N-1:0]   req,
  output logic [ARB_N-1:0]   gnt,
  output logic [ARB_IDW-1:0] gnt_id,
  output logic               gnt_valid,
  output logic               idle
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_e state_q, state_d;
  arb_id_t    ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  arb_vec_t   gnt_q, gnt_d;
  arb_id_t    gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;

  logic       busy;
  logic       cur_held;
  logic       others_req;
  logic       at_limit;
  logic       rotate;
  arb_vec_t   pick_cand;
  arb_id_t    pick_ptr;
  arb_vec_t   pick_onehot;
  arb_id_t    pick_idx;
  logic       pick_found;

  assign busy       = (state_q == BUSY);
  assign cur_held   = req[gnt_id_q];
  assign others_req = |(req & ~gnt_q);
  assign at_limit   = (hold_q == HOLD_LAST);
  assign rotate     = busy && (!cur_held || (at_limit && others_req));

  // While busy, the current owner is masked out and the search starts just
  // past it, so the same pick serves both release and forced rotation.
  assign pick_cand = busy ? (req & ~gnt_q) : req;
  assign pick_ptr  = busy ? next_id(gnt_id_q) : ptr_q;

  rr_pick u_pick (
    .cand   (pick_cand),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = BUSY;
          gnt_d       = pick_onehot;
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
        end
      end
      BUSY: begin
        if (rotate) begin
          ptr_d  = pick_ptr;
          hold_d = '0;
          if (pick_found) begin
            gnt_d       = pick_onehot;
            gnt_id_d    = pick_idx;
            gnt_valid_d = 1'b1;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
          end
        end else if (!at_limit) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign idle      = (state_q == IDLE) && (req == '0);

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q));

  a_valid_match : assert property (@(posedge clk) disable iff (rst)
    gnt_valid_q == (gnt_q != '0));

  a_busy_match : assert property (@(posedge clk) disable iff (rst)
    busy == gnt_valid_q);

  a_hold_range : assert property (@(posedge clk) disable iff (rst)
    hold_q <= HOLD_LAST);

endmodule
